// File: rtl/alu_seq_pkg.sv
// Shared control definitions for the sequential ALU: operation and state encodings,
// flag bit positions and a flag-packing helper.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        ADD   = 4'd0,
        SUB   = 4'd1,
        AND   = 4'd2,
        OR    = 4'd3,
        XOR   = 4'd4,
        PASSB = 4'd5,
        SHL   = 4'd6,
        SHR   = 4'd7,
        MUL   = 4'd8
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    localparam int NUM_FLAGS = 3;
    localparam int FLAG_Z    = 0;
    localparam int FLAG_C    = 1;
    localparam int FLAG_N    = 2;

    function automatic logic [NUM_FLAGS-1:0] pack_flags(input logic n, input logic c, input logic z);
        logic [NUM_FLAGS-1:0] f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_C] = c;
        f[FLAG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU slice: add/sub/logic/pass-B. Any other op passes A through with
// carry clear, which is exactly what a zero-count shift must produce.
module alu_comb
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_e          op,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic [WIDTH-1:0] and_v;
    logic [WIDTH-1:0] or_v;
    logic [WIDTH-1:0] xor_v;
    logic [WIDTH:0]   sum;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bitwise
            assign and_v[gi] = a[gi] & b[gi];
            assign or_v[gi]  = a[gi] | b[gi];
            assign xor_v[gi] = a[gi] ^ b[gi];
        end
    endgenerate

    assign sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        result = a;
        carry  = 1'b0;
        case (op)
            ADD: begin
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
            end
            SUB: begin
                result = a - b;
                carry  = (a >= b);
            end
            AND:     result = and_v;
            OR:      result = or_v;
            XOR:     result = xor_v;
            PASSB:   result = b;
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: IDLE/EXEC/DONE control, bit-serial shifter and optional shift-add
// multiplier (enabled by defining ALU_SEQ_MUL_EN), with a tri-stated result bus.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     acc_direct,
    input  logic [WIDTH-1:0]     bus_in,
    input  alu_op_e              op,
    input  logic                 start,
    input  logic                 out_en,
    output logic [WIDTH-1:0]     bus_out,
    output logic                 busy,
    output logic                 done,
    output logic [NUM_FLAGS-1:0] flags
);

    localparam int CNT_W = ($clog2(WIDTH + 1) > 3) ? $clog2(WIDTH + 1) : 3;

    alu_state_e           state_reg, state_next;
    alu_op_e              op_reg;
    logic [WIDTH-1:0]     result_reg;
    logic [NUM_FLAGS-1:0] flags_reg;
    logic [WIDTH-1:0]     shift_reg;
    logic [WIDTH-1:0]     shift_next;
    logic                 shift_c;
    logic [CNT_W-1:0]     cnt_reg;
    logic [WIDTH-1:0]     comb_result;
    logic                 comb_carry;
    logic [WIDTH-1:0]     fin_result;
    logic                 fin_carry;
    logic [2:0]           shamt;
    logic                 accept;
    logic                 multi;
    logic                 last_step;

    assign shamt     = bus_in[2:0];
    assign accept    = (state_reg == IDLE) && start;
    assign last_step = (cnt_reg == CNT_W'(1));

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .a      (acc_direct),
        .b      (bus_in),
        .op     (op),
        .result (comb_result),
        .carry  (comb_carry)
    );

    always_comb begin
        multi = 1'b0;
        case (op)
            SHL, SHR: multi = (shamt != 3'd0);
`ifdef ALU_SEQ_MUL_EN
            MUL:      multi = 1'b1;
`else
            MUL:      multi = 1'b0;
`endif
            default:  multi = 1'b0;
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = multi ? EXEC : DONE;
            EXEC:    if (last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg != IDLE);
        done = (state_reg == DONE);
    end

    // ---------------- shifter ----------------
    always_comb begin
        if (op_reg == SHR) begin
            shift_next = {1'b0, shift_reg[WIDTH-1:1]};
            shift_c    = shift_reg[0];
        end else begin
            shift_next = {shift_reg[WIDTH-2:0], 1'b0};
            shift_c    = shift_reg[WIDTH-1];
        end
    end

    // ---------------- multiplier ----------------
`ifdef ALU_SEQ_MUL_EN
    logic [2*WIDTH-1:0] prod_reg;
    logic [2*WIDTH-1:0] mcand_reg;
    logic [2*WIDTH-1:0] prod_next;
    logic [WIDTH-1:0]   mplier_reg;

    assign prod_next = prod_reg + (mplier_reg[0] ? mcand_reg : '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prod_reg   <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
        end else if (accept) begin
            prod_reg   <= '0;
            mcand_reg  <= {{WIDTH{1'b0}}, acc_direct};
            mplier_reg <= bus_in;
        end else if (state_reg == EXEC) begin
            prod_reg   <= prod_next;
            mcand_reg  <= {mcand_reg[2*WIDTH-2:0], 1'b0};
            mplier_reg <= {1'b0, mplier_reg[WIDTH-1:1]};
        end
    end
`endif

    // Value committed on the final EXEC edge; working registers never reach the outputs.
    always_comb begin
        fin_result = shift_next;
        fin_carry  = shift_c;
`ifdef ALU_SEQ_MUL_EN
        if (op_reg == MUL) begin
            fin_result = prod_next[WIDTH-1:0];
            fin_carry  = |prod_next[2*WIDTH-1:WIDTH];
        end
`endif
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_reg     <= ADD;
            shift_reg  <= '0;
            cnt_reg    <= '0;
            result_reg <= '0;
            flags_reg  <= '0;
        end else if (accept) begin
            op_reg    <= op;
            shift_reg <= acc_direct;
            cnt_reg   <= (op == MUL) ? CNT_W'(WIDTH) : CNT_W'(shamt);
            // A disabled MUL completes without touching result or flags.
            if (!multi && (op != MUL)) begin
                result_reg <= comb_result;
                flags_reg  <= pack_flags(comb_result[WIDTH-1], comb_carry, comb_result == '0);
            end
        end else if (state_reg == EXEC) begin
            cnt_reg   <= cnt_reg - CNT_W'(1);
            shift_reg <= shift_next;
            if (last_step) begin
                result_reg <= fin_result;
                flags_reg  <= pack_flags(fin_result[WIDTH-1], fin_carry, fin_result == '0);
            end
        end
    end

    assign flags = flags_reg;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bus
            assign bus_out[gi] = out_en ? result_reg[gi] : 1'bz;
        end
    endgenerate

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vectors plus randomized operations checked
// against an arithmetic reference model; honours ALU_SEQ_MUL_EN like the design.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int W = 8;

`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] acc_direct = '0;
    logic [W-1:0] bus_in = '0;
    alu_op_e      op = ADD;
    logic         start = 1'b0;
    logic         out_en = 1'b1;
    wire  [W-1:0] bus_line;
    logic         busy;
    logic         done;
    logic [2:0]   flags;

    // Bench-side driver on the shared bus, used while the ALU is released.
    logic         tb_drv_en = 1'b0;
    logic [W-1:0] tb_drv_val = '0;
    assign bus_line = tb_drv_en ? tb_drv_val : {W{1'bz}};

    int checks = 0;
    int failures = 0;

    logic [W-1:0] exp_res = '0;
    logic [2:0]   exp_flags = '0;

    alu_seq #(.WIDTH(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .acc_direct (acc_direct),
        .bus_in     (bus_in),
        .op         (op),
        .start      (start),
        .out_en     (out_en),
        .bus_out    (bus_line),
        .busy       (busy),
        .done       (done),
        .flags      (flags)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: updates the expected result/flags and returns the expected latency.
    function automatic void model(input alu_op_e o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output int lat);
        int n;
        int s;
        int p;
        logic [W-1:0] r;
        logic c;
        n   = int'(b[2:0]);
        lat = 1;
        r   = a;
        c   = 1'b0;
        case (o)
            ADD: begin
                s = int'(a) + int'(b);
                r = W'(s);
                c = (s >= (1 << W));
            end
            SUB: begin
                s = int'(a) - int'(b);
                r = W'(s);
                c = (a >= b);
            end
            AND:   r = a & b;
            OR:    r = a | b;
            XOR:   r = a ^ b;
            PASSB: r = b;
            SHL: begin
                r   = W'(int'(a) << n);
                c   = (n > 0) ? 1'((int'(a) >> (W - n)) & 1) : 1'b0;
                lat = n + 1;
            end
            SHR: begin
                r   = W'(int'(a) >> n);
                c   = (n > 0) ? 1'((int'(a) >> (n - 1)) & 1) : 1'b0;
                lat = n + 1;
            end
            MUL: begin
                if (!MUL_ON) return;
                p   = int'(a) * int'(b);
                r   = W'(p);
                c   = ((p >> W) != 0);
                lat = W + 1;
            end
            default: ;
        endcase
        exp_res   = r;
        exp_flags = {r[W-1], c, (r == '0)};
    endfunction

    // Waits for completion after the accepting edge and checks latency, result and flags.
    // inject >= 1 pulses start with a different op in that busy cycle.
    task automatic finish_op(input string tag, input alu_op_e o, input logic [W-1:0] a,
                             input logic [W-1:0] b, input int exp_lat,
                             input logic [2:0] prev_flags, input int inject);
        int lat;
        @(posedge clock);
        #1;
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat <= W + 4) begin
            checks++;
            if (busy !== 1'b1 || flags !== prev_flags) begin
                failures++;
                $display("FAIL %s exec: busy=%b flags=%b, required busy=1 flags=%b", tag, busy, flags, prev_flags);
            end
            if (lat == inject) begin
                op         = ADD;
                acc_direct = W'($urandom);
                bus_in     = W'($urandom);
                start      = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clock);
            #1;
            lat++;
        end
        start = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL %s timeout: no done after %0d cycles, required at %0d", tag, lat, exp_lat);
        end else begin
            checks++;
            if (lat != exp_lat) begin
                failures++;
                $display("FAIL %s latency: got %0d, required %0d", tag, lat, exp_lat);
            end
            checks++;
            if (bus_line !== exp_res || flags !== exp_flags || busy !== 1'b1) begin
                failures++;
                $display("FAIL %s result: bus=%h flags=%b busy=%b, required bus=%h flags=%b busy=1",
                         tag, bus_line, flags, busy, exp_res, exp_flags);
            end
            @(posedge clock);
            #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || bus_line !== exp_res) begin
                failures++;
                $display("FAIL %s after: done=%b busy=%b bus=%h, required 0 0 %h", tag, done, busy, bus_line, exp_res);
            end
        end
        $display("%s op=%s a=%h b=%h res=%h flags=%b lat=%0d", tag, o.name(), a, b, bus_line, flags, lat);
    endtask

    task automatic launch(input alu_op_e o, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output logic [2:0] prev);
        acc_direct = a;
        bus_in     = b;
        op         = o;
        start      = 1'b1;
        prev       = exp_flags;
        model(o, a, b, lat);
    endtask

    task automatic run_op(input string tag, input alu_op_e o, input logic [W-1:0] a, input logic [W-1:0] b);
        int lat;
        logic [2:0] prev;
        @(negedge clock);
        launch(o, a, b, lat, prev);
        finish_op(tag, o, a, b, lat, prev, -1);
    endtask

    task automatic test_reset;
        int lat;
        logic [2:0] prev;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || flags !== 3'b000 || bus_line !== '0) begin
            failures++;
            $display("FAIL reset_state: busy=%b done=%b flags=%b bus=%h, required 0 0 000 00", busy, done, flags, bus_line);
        end
        $display("reset_state busy=%b done=%b flags=%b bus=%h", busy, done, flags, bus_line);
        // Start is already requested when reset releases: first edge must accept it.
        @(negedge clock);
        reset = 1'b1;
        launch(ADD, 8'hF0, 8'h20, lat, prev);
        finish_op("add_first", ADD, 8'hF0, 8'h20, lat, prev, -1);
    endtask

    task automatic test_directed;
        run_op("sub_eq", SUB, 8'h05, 8'h05);
        run_op("sub_borrow", SUB, 8'h03, 8'h05);
        run_op("shl_3", SHL, 8'h81, 8'h03);
        run_op("shr_0", SHR, 8'h81, 8'h00);
        run_op("shr_7", SHR, 8'h80, 8'h07);
        run_op("add_set", ADD, 8'h11, 8'h22);
        run_op("mul", MUL, 8'h13, 8'h11);
        run_op("mul_zero", MUL, 8'h00, 8'h37);
    endtask

    task automatic test_bus;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            out_en     = 1'b0;
            tb_drv_val = W'($urandom);
            tb_drv_en  = 1'b1;
            #1;
            checks++;
            if (bus_line !== tb_drv_val) begin
                failures++;
                $display("FAIL bus_release: bus=%h, required bench value %h", bus_line, tb_drv_val);
            end
            tb_drv_en = 1'b0;
            out_en    = 1'b1;
            #1;
            checks++;
            if (bus_line !== exp_res) begin
                failures++;
                $display("FAIL bus_drive: bus=%h, required %h", bus_line, exp_res);
            end
            $display("bus_check drv=%h result=%h", tb_drv_val, bus_line);
        end
    endtask

    task automatic test_start_ignored;
        int lat;
        logic [2:0] prev;
        @(negedge clock);
        launch(SHL, 8'h5A, 8'h05, lat, prev);
        finish_op("shl_ignore", SHL, 8'h5A, 8'h05, lat, prev, 2);
    endtask

    task automatic test_reset_mid_exec;
        int seen;
        @(negedge clock);
        acc_direct = 8'hC3;
        bus_in     = 8'h07;
        op         = SHL;
        start      = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        exp_res   = '0;
        exp_flags = '0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || flags !== 3'b000 || bus_line !== '0) begin
            failures++;
            $display("FAIL abort_state: busy=%b done=%b flags=%b bus=%h, required 0 0 000 00", busy, done, flags, bus_line);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        seen  = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clock);
            #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL abort_no_done: busy/done seen in %0d cycles, required 0", seen);
        end
        $display("abort_mid_exec flags=%b bus=%h activity=%0d", flags, bus_line, seen);
    endtask

    task automatic test_random;
        alu_op_e o;
        for (int i = 0; i < 40; i++) begin
            o = alu_op_e'($urandom_range(0, 8));
            run_op("rand", o, W'($urandom), W'($urandom));
        end
    endtask

    task automatic test_back_to_back;
        run_op("b2b_xor", XOR, 8'hAA, 8'h0F);
        run_op("b2b_or", OR, 8'h00, 8'h00);
        run_op("b2b_and", AND, 8'hF0, 8'h3C);
        run_op("b2b_passb", PASSB, 8'h12, 8'h9C);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_bus();
        test_start_ignored();
        test_reset_mid_exec();
        test_back_to_back();
        test_random();
        test_bus();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, datapath width of operands, result and bus.
REQ-002 SHALL have one clock; reset is asynchronous and active-low, ports named clock and reset.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous active-low reset.
REQ-005 acc_direct  input  WIDTH  operand A, taken straight from the accumulator's direct output.
REQ-006 bus_in  input  WIDTH  operand B from the shared data bus; low 3 bits give the shift count.
REQ-007 op  input  alu_op_e  operation, sampled with start.
REQ-008 start  input  1  request; accepted only in IDLE.
REQ-009 out_en  input  1  drive result onto bus.
REQ-010 bus_out  output  WIDTH  result when out_en=1, else high-impedance (all bits 'z).
REQ-011 busy  output  1  high whenever state != IDLE.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 flags  output  3  {N, C, Z} of the last completed operation.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC, DONE: IDLE->DONE for single-cycle ops; IDLE->EXEC for SHL, SHR and MUL with count>0; EXEC->DONE after the last step; DONE->IDLE unconditionally.
REQ-015 Edge T with start=1 in IDLE SHALL latch A=acc_direct, B=bus_in and op; start while busy SHALL be ignored with no side effect.
REQ-016 ADD, SUB, AND, OR, XOR, PASSB SHALL write result and flags at edge T; done=1 in the cycle after T.
REQ-017 SHL/SHR SHALL shift one bit per edge for n=B[2:0] edges (T+1..T+n), zero fill; done in the cycle after T+n; n=0 behaves as single-cycle with result=A, C=0.
REQ-018 MUL SHALL perform shift-add, one bit per edge over WIDTH edges; result = low WIDTH bits of A*B; done in the cycle after T+WIDTH.
REQ-019 Flags: Z = (result==0); N = result[WIDTH-1]; C = carry out for ADD; C = 1 for SUB when A>=B (no borrow); C = last bit shifted out for shifts; C = (high half != 0) for MUL; C = 0 for logic ops and PASSB.
REQ-020 Result and flags SHALL hold until the next completion; intermediate EXEC values SHALL NOT appear on bus_out or flags.
REQ-021 bus_out SHALL be combinational from out_en and the result register, independent of state.
REQ-022 ADD/SUB SHALL wrap modulo 2^WIDTH.

Reset
REQ-023 reset=0 SHALL immediately force IDLE, result=0, flags=0, done=0, busy=0, aborting any EXEC in progress; no done pulse for the aborted op.
REQ-024 First start SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-025 With ALU_SEQ_MUL_EN defined, MUL SHALL follow REQ-018.
REQ-026 Without ALU_SEQ_MUL_EN, MUL SHALL complete as single-cycle, leave result and flags unchanged, and still pulse done; no multiplier hardware is instantiated.

Structure
REQ-027 alu_op_e (ADD, SUB, AND, OR, XOR, PASSB, SHL, SHR, MUL), alu_state_e and flag bit-index constants SHALL live in the shared control package.
REQ-028 Single-cycle logic/arithmetic SHALL be a sub-module alu_comb; the FSM, shifter and multiplier stay in alu_seq.

Verification
REQ-029 ADD A=0xF0, B=0x20 -> result 0x10, C=1, Z=0, N=0; done exactly one cycle after the accepting edge.
REQ-030 SUB A=0x05, B=0x05 -> result 0x00, Z=1, C=1; then SUB A=0x03, B=0x05 -> 0xFE, N=1, C=0.
REQ-031 SHL A=0x81, B=0x03 -> busy for 4 cycles, result 0x08, C=0; SHR A=0x81, B=0x00 -> result 0x81, done after 1 cycle.
REQ-032 MUL A=0x13, B=0x11 -> result 0x43, C=1, done after WIDTH+1 cycles; without ALU_SEQ_MUL_EN the prior result is retained.
REQ-033 start pulsed during EXEC with different op -> ignored, original result delivered; reset=0 mid-EXEC -> IDLE, flags=0, no done.
REQ-034 out_en=0 -> bus_out all 'z; out_en=1 -> bus_out equals result in the same cycle.
